smg_encode_module: RTL and testbench



---
 rtl/smg_encode_module_if.sv | 23 ++
 rtl/smg_encode_module.sv | 178 +++++++++++++++++
 tb/tb_smg_encode_module.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/smg_encode_module_if.sv
// smg_encode_module_if: countdown value / load handshake in, two
// seven-segment patterns plus status out.
//   master: the side that supplies Bin_Data/Load (phase timer, testbench)
//   slave : smg_encode_module
interface smg_encode_module_if;
    logic [7:0] Bin_Data;
    logic       Load;
    logic [7:0] Ten_SMG_Data;
    logic [7:0] One_SMG_Data;
    logic       Busy;
    logic       Done;
    logic       Over;

    modport master (
        output Bin_Data, Load,
        input  Ten_SMG_Data, One_SMG_Data, Busy, Done, Over
    );

    modport slave (
        input  Bin_Data, Load,
        output Ten_SMG_Data, One_SMG_Data, Busy, Done, Over
    );
endinterface

// File: rtl/smg_encode_module.sv
// smg_encode_module: 8-bit binary countdown value -> two seven-segment
// patterns {dp,g,f,e,d,c,b,a}, via an 8-step shift-and-add-3 BCD converter.
// Optional feature: define SMG_LZB_EN to blank a leading zero on the tens
// digit. Over-range values (>99) show "--" on both digits and raise Over.
// SEG_ACTIVE_LOW = 1 drives common-anode (lit = 0); 0 inverts every pattern.
module smg_encode_module #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    smg_encode_module_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_ENCODE = 2'd2
    } state_t;

    // Active-low codes; polarity is applied once, at the output registers.
    localparam logic [7:0] PAT_BLANK = 8'hFF;
    localparam logic [7:0] PAT_DASH  = 8'hBF;
    localparam logic [7:0] RST_PAT   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    state_t      state_q, state_d;
    logic [7:0]  bin_q,   bin_d;
    logic [11:0] bcd_q,   bcd_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [7:0]  ten_q,   ten_d;
    logic [7:0]  one_q,   one_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic        over_q,  over_d;

    logic [11:0] adj_s;
    logic [19:0] shifted_s;
    logic        tens_blank_s;
    logic        over_s;

    // Add 3 to a BCD nibble that would overflow past 9 after doubling.
    function automatic logic [3:0] add3(input logic [3:0] n);
        logic [3:0] r;
        if (n >= 4'd5) begin
            r = n + 4'd3;
        end else begin
            r = n;
        end
        return r;
    endfunction

    // Active-low segment code for one decimal digit; anything else is blank.
    function automatic logic [7:0] seg_code(input logic [3:0] n);
        logic [7:0] r;
        case (n)
            4'd0:    r = 8'hC0;
            4'd1:    r = 8'hF9;
            4'd2:    r = 8'hA4;
            4'd3:    r = 8'hB0;
            4'd4:    r = 8'h99;
            4'd5:    r = 8'h92;
            4'd6:    r = 8'h82;
            4'd7:    r = 8'hF8;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h90;
            default: r = 8'hFF;
        endcase
        return r;
    endfunction

    // Map an active-low pattern onto the configured display polarity.
    function automatic logic [7:0] pol(input logic [7:0] p);
        logic [7:0] r;
        if (SEG_ACTIVE_LOW) begin
            r = p;
        end else begin
            r = ~p;
        end
        return r;
    endfunction

    // Next-state logic: load, one double-dabble step per SHIFT cycle, encode.
    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        ten_d        = ten_q;
        one_d        = one_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        over_d       = over_q;

        adj_s        = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        shifted_s    = {adj_s, bin_q} << 1'b1;
        over_s       = (bcd_q[11:8] != 4'd0);
`ifdef SMG_LZB_EN
        tens_blank_s = (bcd_q[7:4] == 4'd0);
`else
        tens_blank_s = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.Load) begin
                    state_d = ST_SHIFT;
                    bin_d   = bus.Bin_Data;
                    bcd_d   = 12'd0;
                    cnt_d   = 3'd0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                bcd_d = shifted_s[19:8];
                bin_d = shifted_s[7:0];
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_ENCODE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_ENCODE: begin
                if (over_s) begin
                    ten_d = pol(PAT_DASH);
                    one_d = pol(PAT_DASH);
                end else if (tens_blank_s) begin
                    ten_d = pol(PAT_BLANK);
                    one_d = pol(seg_code(bcd_q[3:0]));
                end else begin
                    ten_d = pol(seg_code(bcd_q[7:4]));
                    one_d = pol(seg_code(bcd_q[3:0]));
                end
                over_d  = over_s;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset aborts any conversion.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            bin_q   <= 8'd0;
            bcd_q   <= 12'd0;
            cnt_q   <= 3'd0;
            ten_q   <= RST_PAT;
            one_q   <= RST_PAT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ten_q   <= ten_d;
            one_q   <= one_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            over_q  <= over_d;
        end
    end

    assign bus.Ten_SMG_Data = ten_q;
    assign bus.One_SMG_Data = one_q;
    assign bus.Busy         = busy_q;
    assign bus.Done         = done_q;
    assign bus.Over         = over_q;

endmodule

// File: tb/tb_smg_encode_module.sv
// tb_smg_encode_module: directed test of smg_encode_module. Two instances
// share the same stimulus: u_al (common-anode, SEG_ACTIVE_LOW=1) and u_ah
// (common-cathode, SEG_ACTIVE_LOW=0, expected codes are the inverse).
// Expected tens pattern for single-digit values follows SMG_LZB_EN.
module tb_smg_encode_module;

    logic CLK;
    logic RST;

    smg_encode_module_if bus_al ();
    smg_encode_module_if bus_ah ();

    smg_encode_module #(.SEG_ACTIVE_LOW(1'b1)) u_al (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_al)
    );

    smg_encode_module #(.SEG_ACTIVE_LOW(1'b0)) u_ah (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_ah)
    );

`ifdef SMG_LZB_EN
    localparam logic [7:0] TEN_ZERO = 8'hFF;
`else
    localparam logic [7:0] TEN_ZERO = 8'hC0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Currently displayed values (active-low form) expected from both DUTs.
    logic [7:0] cur_ten;
    logic [7:0] cur_one;
    logic       cur_over;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic load, input logic [7:0] val);
        bus_al.Load     = load;
        bus_al.Bin_Data = val;
        bus_ah.Load     = load;
        bus_ah.Bin_Data = val;
    endtask

    task automatic check_status(input string tag, input logic busy, input logic done);
        check({tag, "_busy"},    {7'd0, bus_al.Busy}, {7'd0, busy});
        check({tag, "_done"},    {7'd0, bus_al.Done}, {7'd0, done});
        check({tag, "_busy_ah"}, {7'd0, bus_ah.Busy}, {7'd0, busy});
        check({tag, "_done_ah"}, {7'd0, bus_ah.Done}, {7'd0, done});
    endtask

    task automatic check_display(input string tag);
        check({tag, "_ten"},    bus_al.Ten_SMG_Data, cur_ten);
        check({tag, "_one"},    bus_al.One_SMG_Data, cur_one);
        check({tag, "_over"},   {7'd0, bus_al.Over}, {7'd0, cur_over});
        check({tag, "_ten_ah"}, bus_ah.Ten_SMG_Data, ~cur_ten);
        check({tag, "_one_ah"}, bus_ah.One_SMG_Data, ~cur_one);
        check({tag, "_over_ah"}, {7'd0, bus_ah.Over}, {7'd0, cur_over});
    endtask

    // Load val, then Busy for exactly 9 cycles with outputs frozen, then Done
    // with the new patterns, which appear 9 clocks after the accepting edge.
    task automatic convert(input string tag, input logic [7:0] val,
                           input logic [7:0] ten, input logic [7:0] one, input logic ovr);
        drive(1'b1, val);
        tick();
        drive(1'b0, val ^ 8'h5A);
        for (int i = 0; i < 9; i++) begin
            check_status({tag, "_busy_phase"}, 1'b1, 1'b0);
            check_display({tag, "_hold"});
            tick();
        end
        check_status({tag, "_done_phase"}, 1'b0, 1'b1);
        cur_ten  = ten;
        cur_one  = one;
        cur_over = ovr;
        check_display(tag);
    endtask

    initial begin
        RST = 1'b1;
        drive(1'b0, 8'd0);
        cur_ten  = 8'hFF;
        cur_one  = 8'hFF;
        cur_over = 1'b0;

        // Reset state
        tick();
        tick();
        check_status("reset", 1'b0, 1'b0);
        check_display("reset");
        RST = 1'b0;
        tick();
        check_status("idle", 1'b0, 1'b0);
        check_display("idle");

        // Main function, several digits
        convert("v37", 8'd37, 8'hB0, 8'hF8, 1'b0);
        tick();
        check_status("v37_after", 1'b0, 1'b0);
        convert("v5",  8'd5,  TEN_ZERO, 8'h92, 1'b0);
        convert("v0",  8'd0,  TEN_ZERO, 8'hC0, 1'b0);
        convert("v99", 8'd99, 8'h90, 8'h90, 1'b0);

        // Over-range, then back in range clears Over
        convert("v150", 8'd150, 8'hBF, 8'hBF, 1'b1);
        convert("v12",  8'd12,  8'hF9, 8'hA4, 1'b0);
        convert("v255", 8'd255, 8'hBF, 8'hBF, 1'b1);
        convert("v100", 8'd100, 8'hBF, 8'hBF, 1'b1);
        convert("v10",  8'd10,  8'hF9, 8'hC0, 1'b0);

        // Load while Busy is dropped; Bin_Data changes have no effect
        tick();
        drive(1'b1, 8'd42);
        tick();
        drive(1'b0, 8'd77);
        tick();
        tick();
        drive(1'b1, 8'd88);
        tick();
        drive(1'b0, 8'd13);
        check_status("drop_mid", 1'b1, 1'b0);
        check_display("drop_hold");
        for (int i = 0; i < 6; i++) tick();
        check_status("drop_done", 1'b0, 1'b1);
        cur_ten = 8'h99;
        cur_one = 8'hA4;
        cur_over = 1'b0;
        check_display("drop_42");
        for (int i = 0; i < 12; i++) begin
            tick();
            check_status("drop_no_second", 1'b0, 1'b0);
        end
        check_display("drop_stable");

        // Reset at the 5th shift aborts; no Done afterwards
        drive(1'b1, 8'd37);
        tick();
        drive(1'b0, 8'd37);
        for (int i = 0; i < 4; i++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        cur_ten  = 8'hFF;
        cur_one  = 8'hFF;
        cur_over = 1'b0;
        check_status("abort", 1'b0, 1'b0);
        check_display("abort");
        for (int i = 0; i < 12; i++) begin
            tick();
            check_status("abort_no_done", 1'b0, 1'b0);
        end
        convert("v20", 8'd20, 8'hA4, 8'hC0, 1'b0);

        // Back-to-back: Load presented in the Done cycle is accepted
        convert("b2b_37", 8'd37, 8'hB0, 8'hF8, 1'b0);
        convert("b2b_64", 8'd64, 8'h82, 8'h99, 1'b0);
        convert("b2b_81", 8'd81, 8'h80, 8'hF9, 1'b0);
        tick();
        check_status("final", 1'b0, 1'b0);
        check_display("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
